// File: rtl/ibex_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_dmem_pkg
// Description : Shared types and helpers for the LSU-to-SRAM data adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_dmem_pkg;

    // Entry age register width. The stored age counts the cycles an entry
    // has been visible in the queue, so it only has to reach RespLatency (<= 7).
    localparam int unsigned AgeW = 3;

    // Widest data path supported (32-bit data plus 7 integrity bits).
    localparam int unsigned MaxDataWidth = 39;

    // One in-flight response. The stored age of 0 corresponds to the cycle
    // right after the grant, so "age >= RespLatency" on the stored value
    // gives the response timing T+1+RespLatency.
    typedef struct packed {
        logic                    we;
        logic                    err;
        logic [MaxDataWidth-1:0] rdata;
        logic [AgeW-1:0]         age;
    } resp_entry_t;

    // Window check with unsigned 32-bit wrap, so addresses below the base
    // land far above the window and are rejected.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] size);
        logic [31:0] off;
        off = addr - base;
        return (off < size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_dmem_resp_queue.sv
`default_nettype none
// ============================================================================
// Module      : ibex_dmem_resp_queue
// Description : In-order response buffer. Entries are allocated at grant,
//               receive SRAM read data by index one cycle later, and leave
//               from the head once old enough.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_dmem_resp_queue
    import ibex_dmem_pkg::*;
#(
    parameter int unsigned Depth       = 2,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned RespLatency = 0,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alloc_i,
    input  logic                 alloc_we_i,
    input  logic                 alloc_err_i,
    output logic [PtrW-1:0]      alloc_idx_o,
    input  logic                 cap_i,
    input  logic [PtrW-1:0]      cap_idx_i,
    input  logic [DataWidth-1:0] cap_data_i,
    output logic                 pop_o,
    output logic [PtrW-1:0]      head_idx_o,
    output logic                 head_we_o,
    output logic                 head_err_o,
    output logic [DataWidth-1:0] head_rdata_o,
    output logic [CntW-1:0]      count_o
);

    resp_entry_t          entries_q [Depth];
    resp_entry_t          head_entry;
    logic [PtrW-1:0]      head_q, head_d;
    logic [PtrW-1:0]      tail_q, tail_d;
    logic [CntW-1:0]      count_q, count_d;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign head_entry   = entries_q[head_q];
    assign pop_o        = (count_q != '0) && (head_entry.age >= AgeW'(RespLatency));
    assign head_idx_o   = head_q;
    assign head_we_o    = head_entry.we;
    assign head_err_o   = head_entry.err;
    assign head_rdata_o = head_entry.rdata[DataWidth-1:0];
    assign alloc_idx_o  = tail_q;
    assign count_o      = count_q;

    // Storage is sized for the widest data path; the top bits stay zero.
    if (DataWidth < MaxDataWidth) begin : g_rdata_pad
        logic unused_rdata_hi;
        assign unused_rdata_hi = ^head_entry.rdata[MaxDataWidth-1:DataWidth];
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CntW'(alloc_i) - CntW'(pop_o);
        if (pop_o) begin
            head_d = ptr_inc(head_q);
        end
        if (alloc_i) begin
            tail_d = ptr_inc(tail_q);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: ageing, read-data capture and allocation. Capture and
    // allocation never target the same slot because the capture slot was
    // allocated one cycle earlier and is still occupied or being popped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (entries_q[i].age < AgeW'(RespLatency)) begin
                    entries_q[i].age <= entries_q[i].age + AgeW'(1);
                end
            end
            if (cap_i) begin
                entries_q[cap_idx_i].rdata <= MaxDataWidth'(cap_data_i);
            end
            if (alloc_i) begin
                entries_q[tail_q] <= '{we: alloc_we_i, err: alloc_err_i,
                                       rdata: '0, age: '0};
            end
        end
    end

    a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_o && (count_q == '0)));

    a_no_alloc_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(alloc_i && !pop_o && (count_q == CntW'(Depth))));

endmodule
`default_nettype wire

// File: rtl/ibex_dmem_sram_adapter.sv
`default_nettype none
// ============================================================================
// Module      : ibex_dmem_sram_adapter
// Description : LSU data-bus slave driving a single-port synchronous SRAM.
//               Decodes the window, grants while queue space exists, drives
//               the SRAM in the grant cycle and returns in-order responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_dmem_sram_adapter
    import ibex_dmem_pkg::*;
#(
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int unsigned MemSize        = 65536,
    parameter int unsigned RespLatency    = 0,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned DataWidth      = 32,
    localparam int unsigned MemAw = $clog2(MemSize) - 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 data_req_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    output logic                 data_bus_err_o,
    input  logic [31:0]          data_addr_i,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    output logic [DataWidth-1:0] data_rdata_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [MemAw-1:0]     mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic [DataWidth-1:0] mem_rdata_i
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [31:0]          addr_off;
    logic                 in_range;
    logic                 err_req;
    logic                 room;
    logic                 pop;
    logic [CntW-1:0]      count;
    logic [PtrW-1:0]      alloc_idx;
    logic [PtrW-1:0]      head_idx;
    logic                 head_we;
    logic                 head_err;
    logic [DataWidth-1:0] head_rdata;
    logic                 cap_valid_q, cap_valid_d;
    logic [PtrW-1:0]      cap_idx_q, cap_idx_d;
    logic                 cap_bypass;

    // ---------------- decode ----------------
    assign addr_off = data_addr_i - BaseAddr;
    assign in_range = addr_in_range(data_addr_i, BaseAddr, 32'(MemSize));
    assign err_req  = !in_range | (data_addr_i[1:0] != 2'b00);

    // Only the word-index bits of the offset address the SRAM.
    logic unused_off_bits;
    assign unused_off_bits = ^{addr_off[31:MemAw+2], addr_off[1:0]};

    // ---------------- grant ----------------
    // count never exceeds MaxOutstanding, so "count - pop < Max" reduces to
    // "not full, or the head leaves this cycle". pop never looks at req.
    assign room       = (count < CntW'(MaxOutstanding)) | pop;
    assign data_gnt_o = rst_ni & data_req_i & room;

    // ---------------- SRAM drive ----------------
    assign mem_req_o   = data_gnt_o & !err_req;
    assign mem_we_o    = data_we_i;
    assign mem_addr_o  = addr_off[MemAw+1:2];
    assign mem_be_o    = data_be_i;
    assign mem_wdata_o = data_wdata_i;

    // The SRAM answers one cycle after a read strobe; remember which entry
    // that data belongs to.
    assign cap_valid_d = mem_req_o & !data_we_i;
    assign cap_idx_d   = alloc_idx;

    // Capture-target register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_idx_q   <= cap_idx_d;
        end
    end

    ibex_dmem_resp_queue #(
        .Depth       (MaxOutstanding),
        .DataWidth   (DataWidth),
        .RespLatency (RespLatency)
    ) u_resp_queue (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alloc_i      (data_gnt_o),
        .alloc_we_i   (data_we_i),
        .alloc_err_i  (err_req),
        .alloc_idx_o  (alloc_idx),
        .cap_i        (cap_valid_q),
        .cap_idx_i    (cap_idx_q),
        .cap_data_i   (mem_rdata_i),
        .pop_o        (pop),
        .head_idx_o   (head_idx),
        .head_we_o    (head_we),
        .head_err_o   (head_err),
        .head_rdata_o (head_rdata),
        .count_o      (count)
    );

    // ---------------- response ----------------
    // When the head is being captured in its pop cycle the stored copy is
    // not yet written, so forward the SRAM output directly.
    assign cap_bypass = cap_valid_q && (cap_idx_q == head_idx);

    // Response data mux: only error-free reads return data.
    always_comb begin
        data_rdata_o = '0;
        if (pop && !head_we && !head_err) begin
            data_rdata_o = cap_bypass ? mem_rdata_i : head_rdata;
        end
    end

    assign data_rvalid_o  = pop;
    assign data_bus_err_o = pop & head_err;

    a_gnt_needs_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(data_gnt_o && !data_req_i));

endmodule
`default_nettype wire

// File: doc/ibex_dmem_sram_adapter.md
Name: ibex_dmem_sram_adapter

Overview:
Data-side bus slave directly downstream of the load/store unit. It terminates the LSU req/gnt/rvalid protocol, including a second request issued while an earlier response is still pending. It drives a single-port synchronous SRAM (read data one cycle after request) and returns in-order responses after a configurable extra latency. Addresses outside the SRAM window, or not word-aligned, get a bus-error response and no SRAM access.

Parameters:
BaseAddr, 32'h0010_0000, byte base address of SRAM window
MemSize, 65536, window size in bytes; power of two, >= 4
RespLatency, 0, extra cycles beyond SRAM latency before rvalid (0..7)
MaxOutstanding, 2, response queue depth (>= 2)
DataWidth, 32, data width (32, or 39 when integrity bits are carried through)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
data_req_i  in  1  LSU request
data_gnt_o  out  1  request accepted this cycle
data_rvalid_o  out  1  response valid (one-cycle pulse, no backpressure)
data_bus_err_o  out  1  error response; qualified by data_rvalid_o
data_addr_i  in  32  byte address, word-aligned by LSU
data_we_i  in  1  write enable
data_be_i  in  4  byte enables
data_wdata_i  in  DataWidth  write data
data_rdata_o  out  DataWidth  read data; qualified by data_rvalid_o
mem_req_o  out  1  SRAM access strobe
mem_we_o  out  1  SRAM write
mem_addr_o  out  $clog2(MemSize)-2  SRAM word index
mem_be_o  out  4  SRAM byte enables
mem_wdata_o  out  DataWidth  SRAM write data
mem_rdata_i  in  DataWidth  SRAM read data, valid the cycle after mem_req_o

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clk_i is the clock. On reset, all outputs are 0, the queue is empty and all outstanding requests are discarded.
- Reset asserted mid-operation: no rvalid is produced for requests already granted.
- Address decode: in_range = (data_addr_i - BaseAddr) < MemSize, computed as unsigned 32-bit with wrap. err_req = !in_range | (data_addr_i[1:0] != 0).
- Grant: data_gnt_o = data_req_i & (count - pop < MaxOutstanding). This is combinational; pop never depends on data_req_i.
- On grant with !err_req: mem_req_o = 1 in the same cycle. mem_addr_o = (data_addr_i - BaseAddr)[..:2]. we, be and wdata pass straight through.
- On grant with err_req: mem_req_o = 0.
- mem_* address and data outputs are don't-care when mem_req_o = 0; drive them with the pass-through values anyway.
- Queue entry, allocated at grant: {we, err, rdata, age}. age resets to 0 and increments each cycle, saturating at RespLatency+1.
- Read capture: the cycle after a non-error read grant, mem_rdata_i is written into that entry. A registered capture pointer plus valid flag tracks the target entry.
- Eligibility: the head entry is eligible when age >= RespLatency+1. pop = head valid & eligible.
- data_rvalid_o = pop. Responses are strictly in grant order.
- data_bus_err_o = pop & head.err.
- data_rdata_o:
  - head is a read without error: captured data. If the capture for the head happens in the same cycle as pop (always true when RespLatency=0), bypass mem_rdata_i directly.
  - head is a write or an error: 0.
  - pop = 0: 0.
- Latency: grant at cycle T gives rvalid at T+1+RespLatency. With RespLatency=0, back-to-back grants every cycle are sustained.
- Queue full (count = MaxOutstanding, no pop): data_gnt_o = 0 and the request is held by the LSU.
- Full with pop in the same cycle: grant is allowed; allocation and pop happen in the same cycle.
- Errored requests still occupy a queue slot and obey the same latency and ordering as normal requests.
- Pointers are log2(MaxOutstanding) bits, wrapping modulo depth. count is $clog2(MaxOutstanding+1) bits.
- Assertions: no pop when the queue is empty; no allocation when the queue is full; data_gnt_o is never asserted without data_req_i.

Decomposition:
- Package ibex_dmem_pkg: resp_entry_t struct {we, err, rdata, age}; localparam AgeW = 3; helper function addr_in_range(addr, base, size).
- Sub-module ibex_dmem_resp_queue: circular buffer with alloc, capture-by-index and pop-head ports, plus a count output.
- The top level holds decode, grant, SRAM drive and read-data bypass.

Test Plan:
- RespLatency=0, single read of 0x0010_0010 with SRAM word 4 = 0xDEADBEEF -> gnt at T; mem_req_o=1 with mem_addr_o=4 at T; rvalid at T+1 with rdata=0xDEADBEEF, err=0.
- Back-to-back reads 0x0010_0000 then 0x0010_0004 (LSU misaligned-split pattern) -> gnt at T and T+1; rvalid at T+1 and T+2 with the correct word order.
- RespLatency=2, three requests held on data_req_i -> gnt at T and T+1; third grant delayed until the first pop at T+3; rvalids at T+3, T+4, T+6.
- Write 0x0010_0008, be=4'b0110, wdata=0x11223344 -> mem_we_o=1 and mem_be_o=0110; rvalid at T+1 with rdata=0, err=0; a later readback shows only bytes 1-2 changed.
- Read 0x0000_1000 (out of range) and read 0x0010_0002 (unaligned) -> mem_req_o stays 0 for both; rvalid with err=1 and rdata=0, in order.
- Reset asserted the cycle after two grants -> no rvalid afterwards; count=0; the first post-reset request is granted immediately.
